// File: rtl/hdmi_text_axi_regs_if.sv
// hdmi_text_axi_regs_if: AXI4-Lite bus bundle between the interconnect master and the text register file
interface hdmi_text_axi_regs_if #(parameter int ADDR_W = 12);
  logic [ADDR_W-1:0] axi_awaddr;
  logic [2:0]        axi_awprot;
  logic              axi_awvalid;
  logic              axi_awready;
  logic [31:0]       axi_wdata;
  logic [3:0]        axi_wstrb;
  logic              axi_wvalid;
  logic              axi_wready;
  logic [1:0]        axi_bresp;
  logic              axi_bvalid;
  logic              axi_bready;
  logic [ADDR_W-1:0] axi_araddr;
  logic [2:0]        axi_arprot;
  logic              axi_arvalid;
  logic              axi_arready;
  logic [31:0]       axi_rdata;
  logic [1:0]        axi_rresp;
  logic              axi_rvalid;
  logic              axi_rready;
  modport master (
    output axi_awaddr, axi_awprot, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
           axi_araddr, axi_arprot, axi_arvalid, axi_rready,
    input  axi_awready, axi_wready, axi_bresp, axi_bvalid, axi_arready, axi_rdata, axi_rresp, axi_rvalid
  );
  modport slave (
    input  axi_awaddr, axi_awprot, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
           axi_araddr, axi_arprot, axi_arvalid, axi_rready,
    output axi_awready, axi_wready, axi_bresp, axi_bvalid, axi_arready, axi_rdata, axi_rresp, axi_rvalid
  );
endinterface

// File: rtl/hdmi_text_axi_regs.sv
// hdmi_text_axi_regs: AXI4-Lite register file holding 600 VRAM words plus a control word, with a registered video read port
module hdmi_text_axi_regs #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 12,
  parameter int NUM_REGS         = 601
) (
  input  logic                        axi_aclk,
  input  logic                        axi_aresetn,
  hdmi_text_axi_regs_if.slave         s,
  input  logic [9:0]                  vid_addr,
  output logic [C_AXI_DATA_WIDTH-1:0] vid_data,
  output logic [C_AXI_DATA_WIDTH-1:0] ctrl_reg
);
  localparam logic [9:0] VRAM_WORDS = 10'(NUM_REGS - 1);
  localparam logic [9:0] CTRL_IDX   = 10'(NUM_REGS - 1);
  localparam int         AW         = C_AXI_ADDR_WIDTH;
  logic [C_AXI_DATA_WIDTH-1:0] vram [0:NUM_REGS-2];
  logic                        rdy_q, rdy_d;
  logic                        aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [9:0]                  aw_idx_q, aw_idx_d;
  logic [31:0]                 w_data_q, w_data_d;
  logic [3:0]                  w_strb_q, w_strb_d;
  logic                        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]                  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]                 rdata_q, rdata_d, vid_data_q, vid_data_d, ctrl_q, ctrl_d;
  logic                        aw_hs, w_hs, ar_hs, commit, b_done;
  logic [9:0]                  ar_idx;
  logic [31:0]                 wmask, ar_word;
  logic                        unused;
  assign unused        = ^{s.axi_awprot, s.axi_arprot, s.axi_awaddr[1:0], s.axi_araddr[1:0]};
  assign s.axi_awready = rdy_q & ~aw_full_q & ~bvalid_q;
  assign s.axi_wready  = rdy_q & ~w_full_q & ~bvalid_q;
  assign s.axi_arready = rdy_q & ~rvalid_q;
  assign s.axi_bvalid  = bvalid_q;
  assign s.axi_bresp   = bresp_q;
  assign s.axi_rvalid  = rvalid_q;
  assign s.axi_rdata   = rdata_q;
  assign s.axi_rresp   = rresp_q;
  assign vid_data      = vid_data_q;
  assign ctrl_reg      = ctrl_q;
  // Handshakes, write commit, read capture and video lookup
  always_comb begin
    aw_hs      = s.axi_awvalid & s.axi_awready;
    w_hs       = s.axi_wvalid & s.axi_wready;
    ar_hs      = s.axi_arvalid & s.axi_arready;
    commit     = aw_full_q & w_full_q & ~bvalid_q;
    b_done     = bvalid_q & s.axi_bready;
    wmask      = {{8{w_strb_q[3]}}, {8{w_strb_q[2]}}, {8{w_strb_q[1]}}, {8{w_strb_q[0]}}};
    ar_idx     = s.axi_araddr[AW-1:2];
    ar_word    = ar_idx < VRAM_WORDS ? vram[ar_idx] : ar_idx == CTRL_IDX ? ctrl_q : 32'd0;
    rdy_d      = 1'b1;
    aw_full_d  = b_done ? 1'b0 : aw_hs ? 1'b1 : aw_full_q;
    aw_idx_d   = aw_hs ? s.axi_awaddr[AW-1:2] : aw_idx_q;
    w_full_d   = b_done ? 1'b0 : w_hs ? 1'b1 : w_full_q;
    w_data_d   = w_hs ? s.axi_wdata : w_data_q;
    w_strb_d   = w_hs ? s.axi_wstrb : w_strb_q;
    bvalid_d   = commit ? 1'b1 : b_done ? 1'b0 : bvalid_q;
    bresp_d    = commit ? (aw_idx_q <= CTRL_IDX ? 2'b00 : 2'b10) : bresp_q;
    ctrl_d     = commit && aw_idx_q == CTRL_IDX ? (ctrl_q & ~wmask) | (w_data_q & wmask) : ctrl_q;
    rvalid_d   = ar_hs ? 1'b1 : (rvalid_q & s.axi_rready) ? 1'b0 : rvalid_q;
    rdata_d    = ar_hs ? ar_word : rdata_q;
    rresp_d    = ar_hs ? (ar_idx <= CTRL_IDX ? 2'b00 : 2'b10) : rresp_q;
    vid_data_d = vid_addr < VRAM_WORDS ? vram[vid_addr] : 32'd0;
  end
  // Bus state, control word and video register; reset drops any uncommitted write
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      rdy_q      <= 1'b0;
      aw_full_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      vid_data_q <= '0;
      ctrl_q     <= '0;
    end else begin
      rdy_q      <= rdy_d;
      aw_full_q  <= aw_full_d;
      aw_idx_q   <= aw_idx_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      vid_data_q <= vid_data_d;
      ctrl_q     <= ctrl_d;
    end
  end
  // VRAM survives reset; byte-masked commit of the latched write
  always_ff @(posedge axi_aclk) begin
    if (commit && aw_idx_q < VRAM_WORDS) vram[aw_idx_q] <= (vram[aw_idx_q] & ~wmask) | (w_data_q & wmask);
  end
endmodule
